// File: rtl/clk_div_multi.sv
// Multi-channel clock divider: NCH square waves plus per-toggle tick enables,
// reprogrammable through a one-deep valid/ready slot. Optional align restart: CLK_DIV_ALIGN_EN.
module clk_div_multi #(
  parameter int          NCH      = 2,
  parameter int          CNT_W    = 32,
  parameter int unsigned DEF_HALF = 32'd99_999,
  localparam int         CH_W     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_half,
  input  logic             align,
  output logic [NCH-1:0]   clk_out,
  output logic [NCH-1:0]   tick
);

  localparam logic [CNT_W-1:0] DEF_HALF_V = CNT_W'(DEF_HALF);

  logic [CNT_W-1:0] cnt_r  [NCH];
  logic [CNT_W-1:0] half_r [NCH];
  logic [NCH-1:0]   clk_out_r;
  logic [NCH-1:0]   tick_r;
  logic             pend_vld_r;
  logic [CH_W-1:0]  pend_ch_r;
  logic [CNT_W-1:0] pend_half_r;
  logic [NCH-1:0]   drain_s;
  logic             align_s;
  logic             cfg_ok_s;

  function automatic logic ch_in_range(input logic [CH_W-1:0] ch);
    return int'(ch) < NCH;
  endfunction

`ifdef CLK_DIV_ALIGN_EN
  assign align_s = align;
`else
  logic unused_align_s;
  assign unused_align_s = align;
  assign align_s        = 1'b0;
`endif

  assign cfg_ready = ~pend_vld_r;
  assign cfg_ok_s  = ch_in_range(cfg_ch);
  assign clk_out   = clk_out_r;
  assign tick      = tick_r;

  // Decide which channel (if any) consumes the pending slot on this edge.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      drain_s[i] = 1'b0;
      if (pend_vld_r && (pend_ch_r == CH_W'(i))) begin
        if (align_s) begin
          drain_s[i] = 1'b1;
        end else if (!en[i]) begin
          drain_s[i] = 1'b1;
        end else if (cnt_r[i] == half_r[i]) begin
          drain_s[i] = 1'b1;
        end else begin
          drain_s[i] = 1'b0;
        end
      end else begin
        drain_s[i] = 1'b0;
      end
    end
  end

  // Per-channel counters, outputs and half-period reload.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_r[i]  <= {CNT_W{1'b0}};
        half_r[i] <= DEF_HALF_V;
      end
      clk_out_r <= {NCH{1'b0}};
      tick_r    <= {NCH{1'b0}};
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (align_s) begin
          cnt_r[i]     <= {CNT_W{1'b0}};
          clk_out_r[i] <= 1'b0;
          tick_r[i]    <= 1'b0;
          if (drain_s[i]) half_r[i] <= pend_half_r;
        end else if (!en[i]) begin
          // Disabled channels hold phase; a new half restarts the count.
          tick_r[i] <= 1'b0;
          if (drain_s[i]) begin
            half_r[i] <= pend_half_r;
            cnt_r[i]  <= {CNT_W{1'b0}};
          end
        end else if (cnt_r[i] == half_r[i]) begin
          cnt_r[i]     <= {CNT_W{1'b0}};
          clk_out_r[i] <= ~clk_out_r[i];
          tick_r[i]    <= 1'b1;
          if (drain_s[i]) half_r[i] <= pend_half_r;
        end else begin
          cnt_r[i]  <= cnt_r[i] + CNT_W'(1);
          tick_r[i] <= 1'b0;
        end
      end
    end
  end

  // One-deep configuration slot: filled only while empty, so fill and drain never collide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_vld_r  <= 1'b0;
      pend_ch_r   <= {CH_W{1'b0}};
      pend_half_r <= {CNT_W{1'b0}};
    end else if (pend_vld_r) begin
      if (|drain_s) pend_vld_r <= 1'b0;
    end else if (cfg_valid && cfg_ok_s) begin
      pend_vld_r  <= 1'b1;
      pend_ch_r   <= cfg_ch;
      pend_half_r <= cfg_half;
    end
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Randomised self-checking bench for clk_div_multi against a countdown-based
// reference model with a queue for the configuration slot.
module tb_clk_div_multi;

  localparam int NCH      = 3;
  localparam int CNT_W    = 8;
  localparam int DEF_HALF = 3;
  localparam int CH_W     = 2;
`ifdef CLK_DIV_ALIGN_EN
  localparam bit ALIGN_ON = 1'b1;
`else
  localparam bit ALIGN_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [NCH-1:0]   en = '0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch = '0;
  logic [CNT_W-1:0] cfg_half = '0;
  logic             align = 1'b0;
  logic [NCH-1:0]   clk_out;
  logic [NCH-1:0]   tick;

  int checks   = 0;
  int failures = 0;

  // Reference model: remaining cycles to next toggle, level, tick, pending queue.
  int m_half [NCH];
  int m_rem  [NCH];
  bit m_lvl  [NCH];
  bit m_tick [NCH];
  int pq_ch[$];
  int pq_half[$];

  // Requester state: a request is held until the model says it was accepted.
  bit req_active = 1'b0;
  int req_ch     = 0;
  int req_half   = 0;

  always #5 clk = ~clk;

  clk_div_multi #(.NCH(NCH), .CNT_W(CNT_W), .DEF_HALF(DEF_HALF)) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_half(cfg_half), .align(align), .clk_out(clk_out), .tick(tick)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_half[i] = DEF_HALF;
      m_rem[i]  = DEF_HALF;
      m_lvl[i]  = 1'b0;
      m_tick[i] = 1'b0;
    end
    pq_ch.delete();
    pq_half.delete();
  endtask

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic model_step();
    bit ready;
    bit drained;
    bit hit;
    ready   = (pq_ch.size() == 0);
    drained = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      hit = !ready && (pq_ch[0] == i);
      if (ALIGN_ON && align) begin
        if (hit) begin m_half[i] = pq_half[0]; drained = 1'b1; end
        m_rem[i]  = m_half[i];
        m_lvl[i]  = 1'b0;
        m_tick[i] = 1'b0;
      end else if (!en[i]) begin
        m_tick[i] = 1'b0;
        if (hit) begin m_half[i] = pq_half[0]; m_rem[i] = m_half[i]; drained = 1'b1; end
      end else if (m_rem[i] == 0) begin
        m_lvl[i]  = ~m_lvl[i];
        m_tick[i] = 1'b1;
        if (hit) begin m_half[i] = pq_half[0]; drained = 1'b1; end
        m_rem[i]  = m_half[i];
      end else begin
        m_rem[i]  = m_rem[i] - 1;
        m_tick[i] = 1'b0;
      end
    end
    if (drained) begin
      void'(pq_ch.pop_front());
      void'(pq_half.pop_front());
    end
    if (ready && cfg_valid) begin
      if (int'(cfg_ch) < NCH) begin
        pq_ch.push_back(int'(cfg_ch));
        pq_half.push_back(int'(cfg_half));
      end
      req_active = 1'b0;
    end
  endtask

  task automatic check_outputs();
    logic [NCH-1:0] exp_clk;
    logic [NCH-1:0] exp_tick;
    for (int i = 0; i < NCH; i++) begin
      exp_clk[i]  = m_lvl[i];
      exp_tick[i] = m_tick[i];
    end
    check_eq("clk_out", 32'(clk_out), 32'(exp_clk));
    check_eq("tick", 32'(tick), 32'(exp_tick));
    check_eq("cfg_ready", 32'(cfg_ready), 32'(pq_ch.size() == 0));
  endtask

  // One cycle: drive inputs at the falling edge, model the rising edge, check at next falling edge.
  task automatic run_cycles(input int n, input int en_pct, input int align_pct, input int req_pct);
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < NCH; i++) en[i] = ($urandom_range(0, 99) < en_pct);
      align = ($urandom_range(0, 99) < align_pct);
      if (!req_active && ($urandom_range(0, 99) < req_pct)) begin
        req_active = 1'b1;
        req_ch     = $urandom_range(0, 3);
        req_half   = ($urandom_range(0, 15) == 0) ? $urandom_range(20, 60) : $urandom_range(0, 5);
      end
      cfg_valid = req_active;
      cfg_ch    = CH_W'(req_ch);
      cfg_half  = CNT_W'(req_half);
      model_step();
      @(negedge clk);
      check_outputs();
    end
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("rst_clk_out", 32'(clk_out), 32'd0);
    check_eq("rst_tick", 32'(tick), 32'd0);
    check_eq("rst_ready", 32'(cfg_ready), 32'd1);
    rst = 1'b1;

    // Free-running default divider, then randomised traffic.
    run_cycles(40, 100, 0, 0);
    run_cycles(1500, 90, 2, 30);

    // Get a request pending, then hit the async reset mid-period.
    for (int k = 0; k < 300 && pq_ch.size() == 0; k++) begin
      if (!req_active) begin
        req_active = 1'b1;
        req_ch     = $urandom_range(0, 2);
        req_half   = $urandom_range(0, 5);
      end
      run_cycles(1, 100, 0, 0);
    end
    check_eq("pend_setup", 32'(pq_ch.size()), 32'd1);
    run_cycles(2, 100, 0, 0);
    #2 rst = 1'b0;
    #1;
    check_eq("async_clk_out", 32'(clk_out), 32'd0);
    check_eq("async_tick", 32'(tick), 32'd0);
    check_eq("async_ready", 32'(cfg_ready), 32'd1);
    model_reset();
    req_active = 1'b0;
    cfg_valid  = 1'b0;
    align      = 1'b0;
    @(negedge clk);
    check_outputs();
    rst = 1'b1;

    run_cycles(40, 100, 0, 0);
    run_cycles(1500, 80, 3, 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
